ram_req_buf: RTL

Parametrised successor to the single-output request RAM in the display peripheral. It is a WIDTH x DEPTH synchronous buffer that the host fills through a write port. A rising edge on i_request reads one word out to o_valor, with a one-cycle o_valid strobe. The read address comes either from an internal auto-incrementing scan pointer (display refresh) or from an explicit address (random access).

---
 rtl/ram_req_buf.sv | 126 ++++++++++++
 1 files changed

// File: rtl/ram_req_buf.sv
// WIDTH x DEPTH request buffer: host writes words in, a rising edge on i_request reads one word to o_valor.
// Define REQ_SYNC_EN to pass i_request through a 2-flop synchroniser (for sources asynchronous to i_clk).
module ram_req_buf #(
  parameter int WIDTH     = 16,
  parameter int DEPTH     = 16,
  parameter int ADDR_W    = 4,
  parameter     INIT_FILE = ""
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_request,
  input  logic              i_mode,
  input  logic [ADDR_W-1:0] i_rd_addr,
  input  logic              i_rd_restart,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [WIDTH-1:0]  i_wr_data,
  output logic [WIDTH-1:0]  o_valor,
  output logic              o_valid,
  output logic              o_busy,
  output logic [ADDR_W-1:0] o_rd_ptr
);

  typedef enum logic {IDLE = 1'b0, FETCH = 1'b1} state_e;

  localparam logic [ADDR_W:0]   DEPTH_W  = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 1);

  logic [WIDTH-1:0]  mem [DEPTH];
  state_e            state_q;
  logic              req_s;
  logic              req_q;
  logic              rise;
  logic              pend_q;
  logic              seq_q;
  logic              fire_q;
  logic              valid_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [ADDR_W-1:0] rd_ptr_q;
  logic [ADDR_W-1:0] rd_ptr_d;
  logic [WIDTH-1:0]  rd_data_q;
  logic [WIDTH-1:0]  valor_q;

`ifdef REQ_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) sync_q <= '0;
    else       sync_q <= {sync_q[0], i_request};
  end

  assign req_s = sync_q[1];
`else
  assign req_s = i_request;
`endif

  assign rise = req_s & ~req_q;

  // Restart overrides both the hold and the post-read increment; in IDLE this is also the scan read address.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    if (i_rd_restart) begin
      rd_ptr_d = '0;
    end else if (state_q == FETCH && seq_q) begin
      rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      req_q     <= 1'b0;
      pend_q    <= 1'b0;
      seq_q     <= 1'b0;
      fire_q    <= 1'b0;
      rd_addr_q <= '0;
      rd_ptr_q  <= '0;
    end else begin
      req_q    <= req_s;
      rd_ptr_q <= rd_ptr_d;
      fire_q   <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (rise || pend_q) begin
            rd_addr_q <= i_mode ? i_rd_addr : rd_ptr_d;
            seq_q     <= ~i_mode;
            pend_q    <= 1'b0;
            state_q   <= FETCH;
          end
        end
        FETCH: begin
          fire_q  <= 1'b1;
          if (rise) pend_q <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Array has no reset so it maps onto block RAM; the read is read-first against a same-edge write.
  always_ff @(posedge i_clk) begin
    if (i_we && ({1'b0, i_wr_addr} < DEPTH_W)) begin
      mem[i_wr_addr] <= i_wr_data;
    end
    if (state_q == FETCH) begin
      rd_data_q <= ({1'b0, rd_addr_q} < DEPTH_W) ? mem[rd_addr_q] : '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid_q <= 1'b0;
      valor_q <= '0;
    end else begin
      valid_q <= fire_q;
      if (fire_q) valor_q <= rd_data_q;
    end
  end

  assign o_valor  = valor_q;
  assign o_valid  = valid_q;
  assign o_busy   = (state_q == FETCH);
  assign o_rd_ptr = rd_ptr_q;

endmodule
